// File: rtl/conv_result_streamer.sv
// Captures a packed convolution result matrix and streams its elements out
// row-major over a valid/ready handshake, with row/column tags, flags and a checksum.
module conv_result_streamer #(
    parameter int ELEM_W  = 16,
    parameter int MAX_DIM = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                res_valid,
    input  logic [2:0]                          res_m,
    input  logic [2:0]                          res_n,
    input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]   res_data,
    output logic                                busy,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ELEM_W-1:0]                   out_data,
    output logic [2:0]                          out_row,
    output logic [2:0]                          out_col,
    output logic                                out_last_col,
    output logic                                out_last,
    output logic [4:0]                          elem_cnt,
    output logic [20:0]                         checksum,
    output logic                                done,
    output logic                                dim_error
);

    localparam int DATA_W = ELEM_W * MAX_DIM * MAX_DIM;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [2:0]          m_q, m_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic [4:0]          elem_cnt_q, elem_cnt_d;
    logic [20:0]         checksum_q, checksum_d;
    logic                dim_error_q, dim_error_d;

    logic [8:0]          elem_idx;
    logic [ELEM_W-1:0]   cur_elem;
    logic                in_send;
    logic                is_last_col;
    logic                is_last;
    logic                start_ok;

    always_comb begin
        elem_idx    = 9'(row_q) * 9'(MAX_DIM) + 9'(col_q);
        cur_elem    = data_q[elem_idx*ELEM_W +: ELEM_W];
        in_send     = (state_q == SEND);
        is_last_col = ((col_q + 3'd1) == n_q);
        is_last     = is_last_col && ((row_q + 3'd1) == m_q);
        start_ok    = res_valid && (res_m != 3'd0) && (res_n != 3'd0)
                      && (res_m <= 3'(MAX_DIM)) && (res_n <= 3'(MAX_DIM));

        state_d     = state_q;
        data_d      = data_q;
        m_d         = m_q;
        n_d         = n_q;
        row_d       = row_q;
        col_d       = col_q;
        elem_cnt_d  = elem_cnt_q;
        checksum_d  = checksum_q;
        dim_error_d = dim_error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        data_d      = res_data;
                        m_d         = res_m;
                        n_d         = res_n;
                        row_d       = 3'd0;
                        col_d       = 3'd0;
                        elem_cnt_d  = 5'd0;
                        checksum_d  = 21'd0;
                        dim_error_d = 1'b0;
                        state_d     = SEND;
                    end else begin
                        dim_error_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    elem_cnt_d = elem_cnt_q + 5'd1;
                    checksum_d = checksum_q + 21'(cur_elem);
                    if (is_last_col) begin
                        col_d = 3'd0;
                        row_d = row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                    // Park the cursor at the origin so nothing stale leaks out later.
                    if (is_last) begin
                        row_d   = 3'd0;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            m_q         <= 3'd0;
            n_q         <= 3'd0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            elem_cnt_q  <= 5'd0;
            checksum_q  <= 21'd0;
            dim_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            m_q         <= m_d;
            n_q         <= n_d;
            row_q       <= row_d;
            col_q       <= col_d;
            elem_cnt_q  <= elem_cnt_d;
            checksum_q  <= checksum_d;
            dim_error_q <= dim_error_d;
        end
    end

    // Element outputs are forced to zero outside SEND.
    assign out_valid    = in_send;
    assign out_data     = in_send ? cur_elem : '0;
    assign out_row      = in_send ? row_q : 3'd0;
    assign out_col      = in_send ? col_q : 3'd0;
    assign out_last_col = in_send && is_last_col;
    assign out_last     = in_send && is_last;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign elem_cnt     = elem_cnt_q;
    assign checksum     = checksum_q;
    assign dim_error    = dim_error_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomized self-checking bench for conv_result_streamer; expected streams are
// derived from a matrix model held in queues inside the bench.
module tb_conv_result_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         res_valid;
    logic [2:0]   res_m;
    logic [2:0]   res_n;
    logic [399:0] res_data;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [2:0]   out_row;
    logic [2:0]   out_col;
    logic         out_last_col;
    logic         out_last;
    logic [4:0]   elem_cnt;
    logic [20:0]  checksum;
    logic         done;
    logic         dim_error;

    int checks = 0;
    int passes = 0;

    conv_result_streamer dut (
        .clk(clk), .reset(reset), .start(start), .res_valid(res_valid),
        .res_m(res_m), .res_n(res_n), .res_data(res_data), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last_col(out_last_col),
        .out_last(out_last), .elem_cnt(elem_cnt), .checksum(checksum),
        .done(done), .dim_error(dim_error)
    );

    always #5 clk = ~clk;

    // Streams one matrix. ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    // stop_after >= 0 returns right after that many transfers (still in SEND).
    task automatic run_stream(input int m, input int n, input logic [399:0] mat,
                              input int ready_mode, input bit perturb,
                              input int stop_after, output int cycles);
        logic [15:0] exp_d[$];
        int exp_r[$];
        int exp_c[$];
        int sum = 0;
        int k = 0;
        int cyc = 0;
        bit rdy;
        logic [15:0] grid [5][5];
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                grid[r][c] = mat[(r*5+c)*16 +: 16];
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++) begin
                exp_d.push_back(grid[r][c]);
                exp_r.push_back(r);
                exp_c.push_back(c);
            end

        @(negedge clk);
        res_valid = 1'b1; res_m = 3'(m); res_n = 3'(n); res_data = mat; start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL accept_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL accept_busy: got %b expected 1", busy); else passes++;
        checks++; if (elem_cnt !== 5'd0) $display("[TB] FAIL accept_cnt: got %0d expected 0", elem_cnt); else passes++;
        checks++; if (checksum !== 21'd0) $display("[TB] FAIL accept_sum: got %0d expected 0", checksum); else passes++;
        checks++; if (dim_error !== 1'b0) $display("[TB] FAIL accept_dimerr: got %b expected 0", dim_error); else passes++;

        while (k < m*n && k != stop_after && cyc < 300) begin
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (perturb) begin
                res_data = {13{$urandom}};
                res_m = 3'($urandom_range(0, 7));
                res_n = 3'($urandom_range(0, 7));
                res_valid = 1'($urandom_range(0, 1));
                start = (k == 3);
            end
            checks++; if (out_valid !== 1'b1) $display("[TB] FAIL s_valid k=%0d: got %b expected 1", k, out_valid); else passes++;
            checks++; if (out_data !== exp_d[k]) $display("[TB] FAIL s_data k=%0d: got %h expected %h", k, out_data, exp_d[k]); else passes++;
            checks++; if (out_row !== 3'(exp_r[k]) || out_col !== 3'(exp_c[k]))
                $display("[TB] FAIL s_pos k=%0d: got (%0d,%0d) expected (%0d,%0d)", k, out_row, out_col, exp_r[k], exp_c[k]); else passes++;
            checks++; if (out_last_col !== (exp_c[k] == n-1)) $display("[TB] FAIL s_lastcol k=%0d: got %b expected %b", k, out_last_col, exp_c[k] == n-1); else passes++;
            checks++; if (out_last !== (k == m*n-1)) $display("[TB] FAIL s_last k=%0d: got %b expected %b", k, out_last, k == m*n-1); else passes++;
            checks++; if (done !== 1'b0) $display("[TB] FAIL s_done k=%0d: got %b expected 0", k, done); else passes++;
            @(posedge clk);
            if (rdy) begin
                sum += exp_d[k];
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        start = 1'b0;
        cycles = cyc;
        if (cyc >= 300) begin
            checks++;
            $display("[TB] FAIL stream_timeout: got %0d transfers expected %0d", k, m*n);
        end
        if (stop_after < 0) begin
            checks++; if (done !== 1'b1) $display("[TB] FAIL end_done: got %b expected 1", done); else passes++;
            checks++; if (out_valid !== 1'b0) $display("[TB] FAIL end_valid: got %b expected 0", out_valid); else passes++;
            checks++; if (elem_cnt !== 5'(m*n)) $display("[TB] FAIL end_cnt: got %0d expected %0d", elem_cnt, m*n); else passes++;
            checks++; if (checksum !== 21'(sum)) $display("[TB] FAIL end_sum: got %0d expected %0d", checksum, sum); else passes++;
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL post_done: got done=%b busy=%b expected 0/0", done, busy); else passes++;
            checks++; if (elem_cnt !== 5'(m*n) || checksum !== 21'(sum))
                $display("[TB] FAIL post_hold: got %0d/%0d expected %0d/%0d", elem_cnt, checksum, m*n, sum); else passes++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; res_valid = 1'b0; res_m = 3'd0; res_n = 3'd0;
        res_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, out_valid, done, dim_error, out_last, out_last_col} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b expected 000000", {busy, out_valid, done, dim_error, out_last, out_last_col}); else passes++;
        checks++; if (out_data !== 16'd0 || elem_cnt !== 5'd0 || checksum !== 21'd0)
            $display("[TB] FAIL reset_values: got %h/%0d/%0d expected 0", out_data, elem_cnt, checksum); else passes++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_3x3_full();
        logic [399:0] mat = '0;
        int cyc;
        for (int i = 0; i < 9; i++) mat[((i/3)*5 + i%3)*16 +: 16] = 16'(i + 1);
        run_stream(3, 3, mat, 0, 1'b0, -1, cyc);
        checks++; if (cyc != 9) $display("[TB] FAIL full_cycles: got %0d expected 9", cyc); else passes++;
        checks++; if (checksum !== 21'd45) $display("[TB] FAIL full_sum45: got %0d expected 45", checksum); else passes++;
    endtask

    task automatic test_3x3_stall();
        logic [399:0] mat = '0;
        int cyc;
        for (int i = 0; i < 9; i++) mat[((i/3)*5 + i%3)*16 +: 16] = 16'(i + 1);
        run_stream(3, 3, mat, 1, 1'b0, -1, cyc);
        checks++; if (cyc != 25) $display("[TB] FAIL stall_cycles: got %0d expected 25", cyc); else passes++;
        checks++; if (checksum !== 21'd45) $display("[TB] FAIL stall_sum45: got %0d expected 45", checksum); else passes++;
    endtask

    task automatic test_1x1();
        logic [399:0] mat = '0;
        int cyc;
        mat[15:0] = 16'hFFFF;
        run_stream(1, 1, mat, 0, 1'b0, -1, cyc);
        checks++; if (checksum !== 21'h0FFFF || elem_cnt !== 5'd1)
            $display("[TB] FAIL one_by_one: got %h/%0d expected 0ffff/1", checksum, elem_cnt); else passes++;
    endtask

    task automatic test_reject();
        logic [399:0] mat;
        int cyc;
        logic [4:0] prev_cnt = elem_cnt;
        logic [20:0] prev_sum = checksum;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            res_valid = (pass == 1) ? 1'b0 : 1'b1;
            res_m = (pass == 0) ? 3'd0 : 3'd3;
            res_n = 3'd3;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++; if (dim_error !== 1'b1) $display("[TB] FAIL rej%0d_dimerr: got %b expected 1", pass, dim_error); else passes++;
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rej%0d_idle: got valid=%b busy=%b expected 0/0", pass, out_valid, busy); else passes++;
            checks++; if (elem_cnt !== prev_cnt || checksum !== prev_sum)
                $display("[TB] FAIL rej%0d_hold: got %0d/%0d expected %0d/%0d", pass, elem_cnt, checksum, prev_cnt, prev_sum); else passes++;
        end
        mat = {13{$urandom}};
        run_stream(2, 3, mat, 2, 1'b0, -1, cyc);
    endtask

    task automatic test_5x5_latch();
        logic [399:0] mat;
        int cyc;
        for (int i = 0; i < 25; i++) mat[i*16 +: 16] = 16'(i);
        run_stream(5, 5, mat, 2, 1'b1, -1, cyc);
        checks++; if (checksum !== 21'd300) $display("[TB] FAIL latch_sum300: got %0d expected 300", checksum); else passes++;
        res_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [399:0] mat = '0;
        int cyc;
        for (int i = 0; i < 9; i++) mat[((i/3)*5 + i%3)*16 +: 16] = 16'(i + 1);
        run_stream(3, 3, mat, 0, 1'b0, 4, cyc);
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, out_valid, done, out_last, out_last_col} !== 5'b0)
            $display("[TB] FAIL midrst_flags: got %b expected 00000", {busy, out_valid, done, out_last, out_last_col}); else passes++;
        checks++; if (out_data !== 16'd0 || out_row !== 3'd0 || out_col !== 3'd0 || elem_cnt !== 5'd0 || checksum !== 21'd0)
            $display("[TB] FAIL midrst_values: got %h (%0d,%0d) %0d %0d expected 0", out_data, out_row, out_col, elem_cnt, checksum); else passes++;
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || out_valid !== 1'b0)
                $display("[TB] FAIL midrst_quiet%0d: got done=%b valid=%b expected 0/0", i, done, out_valid); else passes++;
        end
        run_stream(3, 3, mat, 0, 1'b0, -1, cyc);
    endtask

    task automatic test_random();
        logic [399:0] mat;
        int cyc;
        for (int t = 0; t < 6; t++) begin
            mat = {13{$urandom}};
            run_stream(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), mat, 2, 1'b0, -1, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_3x3_full();
        test_3x3_stall();
        test_1x1();
        test_reject();
        test_5x5_latch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
